// File: rtl/cpu_pkg.sv
// Shared datapath sizing for the mini CPU: register width, register count and
// the address-width derivation used by decode, hazard logic and the register file.
package cpu_pkg;

  localparam int CPU_DATA_W   = 8;
  localparam int CPU_NUM_REGS = 4;

  function automatic int cpu_addr_w(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: committed value and busy bit, overridden by
// same-cycle write data when forwarding is enabled, and forced to zero for a hardwired R0.
module regfile_rd_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int NUM_REGS = CPU_NUM_REGS,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 0,
  localparam int ADDR_W  = cpu_addr_w(NUM_REGS)
) (
  input  logic [ADDR_W-1:0]   ra,
  input  logic [DATA_W-1:0]   regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] busy,
  input  logic                we0,
  input  logic [ADDR_W-1:0]   wa0,
  input  logic [DATA_W-1:0]   wd0,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   wa1,
  input  logic [DATA_W-1:0]   wd1,
  output logic [DATA_W-1:0]   rd,
  output logic                rd_busy
);

  logic [DATA_W-1:0] w_rd;
  logic              w_busy;

  always_comb begin
    w_rd   = regs[ra];
    w_busy = busy[ra];
    // Forwarded data is already available, so the consumer need not stall.
    if (BYPASS != 0) begin
      if (we1 && (wa1 == ra)) begin
        w_rd   = wd1;
        w_busy = 1'b0;
      end else if (we0 && (wa0 == ra)) begin
        w_rd   = wd0;
        w_busy = 1'b0;
      end
    end
    if ((ZERO_R0 != 0) && (ra == '0)) begin
      w_rd   = '0;
      w_busy = 1'b0;
    end
  end

  assign rd      = w_rd;
  assign rd_busy = w_busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file: two combinational reads, two writes (port 1 wins on
// collision), optional forwarding and hardwired R0, plus a per-register busy scoreboard.
module regfile_mp_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int NUM_REGS = CPU_NUM_REGS,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 0,
  localparam int ADDR_W  = cpu_addr_w(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          ra1,
  input  logic [ADDR_W-1:0]          ra2,
  output logic [DATA_W-1:0]          rd1,
  output logic [DATA_W-1:0]          rd2,
  output logic                       rd1_busy,
  output logic                       rd2_busy,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [DATA_W-1:0]          wd0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd1,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic                       wr_conflict,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                r_conflict;

  logic w_we0;
  logic w_we1;
  logic w_set;

  // Writes and issues aimed at a hardwired R0 vanish before they reach any state.
  assign w_we0 = we0 && !((ZERO_R0 != 0) && (wa0 == '0));
  assign w_we1 = we1 && !((ZERO_R0 != 0) && (wa1 == '0));
  assign w_set = iss_valid && !((ZERO_R0 != 0) && (iss_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_we1 && (wa1 == ADDR_W'(i))) begin
          r_regs[i] <= wd1;
        end else if (w_we0 && (wa0 == ADDR_W'(i))) begin
          r_regs[i] <= wd0;
        end
      end
    end
  end

  // A new producer issued in the same cycle an older one retires keeps the register busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_set && (iss_addr == ADDR_W'(i))) begin
          r_busy[i] <= 1'b1;
        end else if ((w_we0 && (wa0 == ADDR_W'(i))) || (w_we1 && (wa1 == ADDR_W'(i)))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_we0 && w_we1 && (wa0 == wa1);
    end
  end

  assign wr_conflict = r_conflict;

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
    end
  endgenerate

  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS),
    .ZERO_R0  (ZERO_R0)
  ) u_rd1 (
    .ra      (ra1),
    .regs    (r_regs),
    .busy    (r_busy),
    .we0     (w_we0),
    .wa0     (wa0),
    .wd0     (wd0),
    .we1     (w_we1),
    .wa1     (wa1),
    .wd1     (wd1),
    .rd      (rd1),
    .rd_busy (rd1_busy)
  );

  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS),
    .ZERO_R0  (ZERO_R0)
  ) u_rd2 (
    .ra      (ra2),
    .regs    (r_regs),
    .busy    (r_busy),
    .we0     (w_we0),
    .wa0     (wa0),
    .wd0     (wd0),
    .we1     (w_we1),
    .wa1     (wa1),
    .wd1     (wd1),
    .rd      (rd2),
    .rd_busy (rd2_busy)
  );

endmodule
